// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding control for an in-order pipeline: tracks in-flight destinations per stage,
// raises load-use / RAW stalls, selects EXE operand bypass sources and counts stall cycles.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned SEL_W     = $clog2(STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  forwarding_enable,
    input  logic                  mem_ready,
    input  logic                  branch_taken,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src1_used,
    input  logic                  id_src2_used,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    output logic                  freeze,
    output logic                  flush,
    output logic                  mem_stall,
    output logic [SEL_W-1:0]      src1_sel,
    output logic [SEL_W-1:0]      src2_sel,
    output logic [CNT_W-1:0]      stall_count
);

    logic [STAGES:1]                 valid_q, valid_d;
    logic [STAGES:1]                 wb_q, wb_d;
    logic [STAGES:1]                 load_q, load_d;
    logic [STAGES:1][REG_ADDR_W-1:0] dest_q, dest_d;
    logic [REG_ADDR_W-1:0]           ex_src1_q, ex_src1_d, ex_src2_q, ex_src2_d;
    logic                            ex_use1_q, ex_use1_d, ex_use2_q, ex_use2_d;
    logic [CNT_W-1:0]                stall_count_q, stall_count_d;
    logic                            hazard;

    // With forwarding only a load still in EXE stalls; without it every producer short of WB
    // stalls, since WB writes the register file before ID reads it.
    always_comb begin
        hazard = 1'b0;
        for (int k = 1; k <= int'(STAGES); k++) begin
            if (valid_q[k] && wb_q[k] &&
                ((id_src1_used && (dest_q[k] == id_src1)) ||
                 (id_src2_used && (dest_q[k] == id_src2)))) begin
                if (forwarding_enable) begin
                    if (k == 1 && load_q[k]) hazard = 1'b1;
                end else if (k < int'(STAGES)) begin
                    hazard = 1'b1;
                end
            end
        end
        if (!id_valid || branch_taken) hazard = 1'b0;
    end

    assign mem_stall   = ~mem_ready;
    assign freeze      = rst & (hazard | mem_stall);
    assign flush       = branch_taken;
    assign stall_count = stall_count_q;

    // Scan oldest to youngest so the youngest matching producer overrides.
    always_comb begin
        src1_sel = '0;
        src2_sel = '0;
        if (forwarding_enable && valid_q[1]) begin
            for (int k = int'(STAGES); k >= 2; k--) begin
                if (valid_q[k] && wb_q[k]) begin
                    if (ex_use1_q && (dest_q[k] == ex_src1_q)) src1_sel = SEL_W'(k - 1);
                    if (ex_use2_q && (dest_q[k] == ex_src2_q)) src2_sel = SEL_W'(k - 1);
                end
            end
        end
    end

    always_comb begin
        valid_d       = valid_q;
        wb_d          = wb_q;
        load_d        = load_q;
        dest_d        = dest_q;
        ex_src1_d     = ex_src1_q;
        ex_src2_d     = ex_src2_q;
        ex_use1_d     = ex_use1_q;
        ex_use2_d     = ex_use2_q;
        stall_count_d = stall_count_q;
        if (!mem_stall) begin
            for (int k = 2; k <= int'(STAGES); k++) begin
                valid_d[k] = valid_q[k-1];
                wb_d[k]    = wb_q[k-1];
                load_d[k]  = load_q[k-1];
                dest_d[k]  = dest_q[k-1];
            end
            valid_d[1] = id_valid & ~hazard & ~branch_taken;
            wb_d[1]    = id_wb_en;
            load_d[1]  = id_mem_r_en;
            dest_d[1]  = id_dest;
            ex_src1_d  = id_src1;
            ex_src2_d  = id_src2;
            ex_use1_d  = id_src1_used;
            ex_use2_d  = id_src2_used;
            if (hazard && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q       <= '0;
            wb_q          <= '0;
            load_q        <= '0;
            dest_q        <= '0;
            ex_src1_q     <= '0;
            ex_src2_q     <= '0;
            ex_use1_q     <= 1'b0;
            ex_use2_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            wb_q          <= wb_d;
            load_q        <= load_d;
            dest_q        <= dest_d;
            ex_src1_q     <= ex_src1_d;
            ex_src2_q     <= ex_src2_d;
            ex_use1_q     <= ex_use1_d;
            ex_use2_q     <= ex_use2_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: table of per-cycle vectors on the default configuration, plus hand-written
// sequences on a STAGES=4 / CNT_W=2 instance sharing the same inputs.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic fwd, mr, br, idv, u1, u2, wb, ld;
    logic [3:0] s1, s2, dst;

    logic        a_frz, a_fl, a_ms;
    logic [1:0]  a_sel1, a_sel2;
    logic [15:0] a_cnt;
    logic        b_frz, b_fl, b_ms;
    logic [1:0]  b_sel1, b_sel2;
    logic [1:0]  b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(4), .STAGES(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .forwarding_enable(fwd), .mem_ready(mr), .branch_taken(br),
        .id_valid(idv), .id_src1(s1), .id_src2(s2), .id_src1_used(u1), .id_src2_used(u2),
        .id_dest(dst), .id_wb_en(wb), .id_mem_r_en(ld),
        .freeze(a_frz), .flush(a_fl), .mem_stall(a_ms), .src1_sel(a_sel1), .src2_sel(a_sel2),
        .stall_count(a_cnt)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(4), .STAGES(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .forwarding_enable(fwd), .mem_ready(mr), .branch_taken(br),
        .id_valid(idv), .id_src1(s1), .id_src2(s2), .id_src1_used(u1), .id_src2_used(u2),
        .id_dest(dst), .id_wb_en(wb), .id_mem_r_en(ld),
        .freeze(b_frz), .flush(b_fl), .mem_stall(b_ms), .src1_sel(b_sel1), .src2_sel(b_sel2),
        .stall_count(b_cnt)
    );

    typedef struct {
        logic       fwd, mr, br, v;
        logic [3:0] s1;
        logic       u1;
        logic [3:0] s2;
        logic       u2;
        logic [3:0] d;
        logic       wb, ld;
        logic       frz, fl, ms;
        logic [1:0] sel1, sel2;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic f, m, b, v, input logic [3:0] a1, input logic e1,
                       input logic [3:0] a2, input logic e2, input logic [3:0] d,
                       input logic w, l, input logic xfrz, xfl, xms,
                       input logic [1:0] xs1, xs2, input int xcnt);
        vec_t t;
        t = '{f, m, b, v, a1, e1, a2, e2, d, w, l, xfrz, xfl, xms, xs1, xs2, xcnt};
        vecs.push_back(t);
    endtask

    task automatic drive(input logic f, m, b, v, input logic [3:0] a1, input logic e1,
                         input logic [3:0] a2, input logic e2, input logic [3:0] d,
                         input logic w, l);
        fwd = f; mr = m; br = b; idv = v; s1 = a1; u1 = e1; s2 = a2; u2 = e2;
        dst = d; wb = w; ld = l;
    endtask

    task automatic nop();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // fwd mr br v  s1 u1 s2 u2 d wb ld | frz fl ms sel1 sel2 cnt
        // Forwarding chain: ADD r3, SUB uses r3 (sel1=1), AND uses r3 a cycle later (sel2=2)
        add(1,1,0,1,  1,1, 2,1, 3,1,0,  0,0,0, 0,0, 0);
        add(1,1,0,1,  3,1, 6,1, 4,1,0,  0,0,0, 0,0, 0);
        add(1,1,0,1,  8,1, 3,1, 7,1,0,  0,0,0, 1,0, 0);
        add(1,1,0,0,  0,0, 0,0, 0,0,0,  0,0,0, 0,2, 0);
        // Load-use: one stall; consumer reaches EXE with the load in WB
        add(1,1,0,1,  9,1, 0,0, 5,1,1,  0,0,0, 0,0, 0);
        add(1,1,0,1, 11,1, 5,1,10,1,0,  1,0,0, 0,0, 0);
        add(1,1,0,1, 11,1, 5,1,10,1,0,  0,0,0, 0,0, 1);
        add(1,1,0,0,  0,0, 0,0, 0,0,0,  0,0,0, 0,2, 1);
        // Stall-only mode: two stall cycles, never forwards
        add(0,1,0,1, 12,1, 0,0, 2,1,0,  0,0,0, 0,0, 1);
        add(0,1,0,1,  2,1,14,1,13,1,0,  1,0,0, 0,0, 1);
        add(0,1,0,1,  2,1,14,1,13,1,0,  1,0,0, 0,0, 2);
        add(0,1,0,1,  2,1,14,1,13,1,0,  0,0,0, 0,0, 3);
        add(0,1,0,0,  0,0, 0,0, 0,0,0,  0,0,0, 0,0, 3);
        // Hazard suppressed by a taken branch
        add(1,1,0,1,  1,1, 0,0, 6,1,1,  0,0,0, 0,0, 3);
        add(1,1,1,1,  6,1, 6,1, 7,1,0,  0,1,0, 0,0, 3);
        add(1,1,0,0,  0,0, 0,0, 0,0,0,  0,0,0, 0,0, 3);
        // Unused source matching a load dest: no stall, no forward
        add(1,1,0,1,  1,1, 0,0, 8,1,1,  0,0,0, 0,0, 3);
        add(1,1,0,1,  1,1, 8,0, 9,1,0,  0,0,0, 0,0, 3);
        add(1,1,0,0,  0,0, 0,0, 0,0,0,  0,0,0, 0,0, 3);
        // Memory busy for three cycles with a load-use pending
        add(1,1,0,1,  1,1, 0,0, 4,1,1,  0,0,0, 0,0, 3);
        add(1,0,0,1,  4,1, 0,0, 5,1,0,  1,0,1, 0,0, 3);
        add(1,0,0,1,  4,1, 0,0, 5,1,0,  1,0,1, 0,0, 3);
        add(1,0,0,1,  4,1, 0,0, 5,1,0,  1,0,1, 0,0, 3);
        add(1,1,0,1,  4,1, 0,0, 5,1,0,  1,0,0, 0,0, 3);
        add(1,1,0,1,  4,1, 0,0, 5,1,0,  0,0,0, 0,0, 4);
        // Memory busy together with a taken branch: nothing moves, flush held
        add(1,0,1,0,  0,0, 0,0, 0,0,0,  1,1,1, 2,0, 4);
        add(1,1,1,0,  0,0, 0,0, 0,0,0,  0,1,0, 2,0, 4);
        add(1,1,0,0,  0,0, 0,0, 0,0,0,  0,0,0, 0,0, 4);

        // Reset state with memory busy and branch pending
        rst = 1'b0;
        drive(1, 0, 1, 1, 3, 1, 3, 1, 3, 1, 1);
        #2;
        chk("reset a_freeze", a_frz, 0);
        chk("reset a_mem_stall", a_ms, 1);
        chk("reset a_flush", a_fl, 1);
        chk("reset a_sel", {a_sel1, a_sel2}, 0);
        chk("reset a_count", a_cnt, 0);
        chk("reset b_freeze", b_frz, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].fwd, vecs[i].mr, vecs[i].br, vecs[i].v, vecs[i].s1, vecs[i].u1,
                  vecs[i].s2, vecs[i].u2, vecs[i].d, vecs[i].wb, vecs[i].ld);
            #2;
            n_checks++;
            if (a_frz !== vecs[i].frz || a_fl !== vecs[i].fl || a_ms !== vecs[i].ms ||
                a_sel1 !== vecs[i].sel1 || a_sel2 !== vecs[i].sel2 ||
                a_cnt !== 16'(vecs[i].cnt)) begin
                n_errors++;
                $display("FAIL vec%0d: got frz=%b fl=%b ms=%b sel1=%0d sel2=%0d cnt=%0d, expected frz=%b fl=%b ms=%b sel1=%0d sel2=%0d cnt=%0d",
                         i, a_frz, a_fl, a_ms, a_sel1, a_sel2, a_cnt, vecs[i].frz, vecs[i].fl,
                         vecs[i].ms, vecs[i].sel1, vecs[i].sel2, vecs[i].cnt);
            end
            next_cycle();
        end

        // Deeper pipe: youngest of two r1 producers wins, then counter saturation
        rst = 1'b0;
        nop();
        next_cycle();
        rst = 1'b1;
        drive(1, 1, 0, 1, 3, 1, 0, 0, 1, 1, 0);
        next_cycle();
        drive(1, 1, 0, 1, 3, 1, 0, 0, 9, 1, 0);
        next_cycle();
        drive(1, 1, 0, 1, 3, 1, 0, 0, 1, 1, 0);
        next_cycle();
        drive(1, 1, 0, 1, 1, 1, 9, 1, 10, 1, 0);
        #2;
        chk("b non-load producer no stall", b_frz, 0);
        next_cycle();
        nop();
        #2;
        chk("b sel1 youngest r1", b_sel1, 1);
        chk("b sel2 r9 in stage3", b_sel2, 2);
        next_cycle();

        for (int it = 1; it <= 5; it++) begin
            drive(1, 1, 0, 1, 3, 1, 0, 0, 2, 1, 1);
            next_cycle();
            drive(1, 1, 0, 1, 2, 1, 0, 0, 4, 1, 0);
            #2;
            chk($sformatf("b load-use stall %0d", it), b_frz, 1);
            next_cycle();
            next_cycle();
            chk($sformatf("b count after %0d", it), b_cnt, (it < 3) ? it : 3);
        end

        nop();
        #2;
        chk("b sel1 before reset", b_sel1, 2);
        #1 rst = 1'b0;
        #1;
        chk("async reset b_count", b_cnt, 0);
        chk("async reset b_sel", {b_sel1, b_sel2}, 0);
        chk("async reset a_count", a_cnt, 0);
        next_cycle();
        rst = 1'b1;
        drive(1, 1, 0, 1, 3, 1, 0, 0, 2, 1, 1);
        next_cycle();
        drive(1, 1, 0, 1, 2, 1, 0, 0, 4, 1, 0);
        #2;
        chk("post-reset load-use stall", b_frz, 1);
        next_cycle();
        chk("post-reset count", b_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
